// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter/rotator: one registered stage per shift-amount bit,
// valid/ready on both sides, with zero, carry-out and illegal-op flags.
module shift_unit_pipe #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Stage k holds the operand after applying shamt bits 0..k.
  logic [SHW-1:0]   st_valid;
  logic [WIDTH-1:0] st_data [SHW];
  logic [SHW-1:0]   st_carry;
  logic [SHW-1:0]   st_err;
  logic [2:0]       st_op  [SHW-1];
  logic [SHW-1:0]   st_rem [SHW-1];

  logic             stall;
  logic             entry_carry;
  logic [SHW-1:0]   idx_l;
  logic [SHW-1:0]   idx_r;
  logic [WIDTH-1:0] last_data_nxt;

  function automatic logic [WIDTH-1:0] stage_shift(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input logic             en,
    input int unsigned      amt
  );
    logic [WIDTH-1:0] r;
    r = d;
    if (en) begin
      case (op)
        OP_SLL:  r = d << amt;
        OP_SRL:  r = d >> amt;
        OP_SRA:  r = WIDTH'($signed(d) >>> amt);
        OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
        OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
        default: r = d;
      endcase
    end
    return r;
  endfunction

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = st_valid[SHW-1];
  assign out_data  = st_data[SHW-1];
  assign out_carry = st_carry[SHW-1];
  assign out_err   = st_err[SHW-1];

  // Carry is taken from the original operand: A[WIDTH-n] leftward, A[n-1] rightward.
  always_comb begin
    idx_l       = SHW'(0) - in_shamt;
    idx_r       = in_shamt - SHW'(1);
    entry_carry = 1'b0;
    if (in_shamt != '0) begin
      case (in_op)
        OP_SLL, OP_ROL:         entry_carry = in_data[idx_l];
        OP_SRL, OP_SRA, OP_ROR: entry_carry = in_data[idx_r];
        default:                entry_carry = 1'b0;
      endcase
    end
    last_data_nxt = stage_shift(st_data[SHW-2], st_op[SHW-2], st_rem[SHW-2][0],
                                32'(1) << (SHW - 1));
  end

  // Whole pipeline advances in lockstep unless the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_valid <= '0;
      st_carry <= '0;
      st_err   <= '0;
      out_zero <= 1'b0;
      for (int k = 0; k < SHW; k++) st_data[k] <= '0;
      for (int k = 0; k < SHW - 1; k++) begin
        st_op[k]  <= '0;
        st_rem[k] <= '0;
      end
    end else if (!stall) begin
      st_valid[0] <= in_valid;
      if (in_valid) begin
        st_data[0]  <= stage_shift(in_data, in_op, in_shamt[0], 32'd1);
        st_carry[0] <= entry_carry;
        st_err[0]   <= (in_op > OP_ROR);
        st_op[0]    <= in_op;
        st_rem[0]   <= in_shamt >> 1;
      end
      for (int k = 1; k < SHW; k++) begin
        st_valid[k] <= st_valid[k-1];
        if (st_valid[k-1]) begin
          st_data[k]  <= stage_shift(st_data[k-1], st_op[k-1], st_rem[k-1][0],
                                     32'(1) << k);
          st_carry[k] <= st_carry[k-1];
          st_err[k]   <= st_err[k-1];
        end
      end
      for (int k = 1; k < SHW - 1; k++) begin
        if (st_valid[k-1]) begin
          st_op[k]  <= st_op[k-1];
          st_rem[k] <= st_rem[k-1] >> 1;
        end
      end
      if (st_valid[SHW-2]) out_zero <= (last_data_nxt == '0);
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (WIDTH=16): per-op results and latency,
// backpressure ordering, illegal ops and mid-flight reset.
module tb_shift_unit_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;
  localparam int unsigned NVEC  = 14;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shamt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] d;
    logic             c;
  } vec_t;

  vec_t vecs [NVEC];

  shift_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i);
    in_valid = 1'b1;
    in_op    = vecs[i].op;
    in_data  = vecs[i].a;
    in_shamt = vecs[i].n;
  endtask

  task automatic check_result(input string tag, input int i);
    chk({tag, "_data"},  32'(out_data),  32'(vecs[i].d));
    chk({tag, "_carry"}, 32'(out_carry), 32'(vecs[i].c));
    chk({tag, "_zero"},  32'(out_zero),  32'(vecs[i].d == '0));
    chk({tag, "_err"},   32'(out_err),   32'(vecs[i].op > 3'b100));
  endtask

  // Issue one op alone, measure latency, then check the result.
  task automatic run_single(input int i);
    int lat;
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    chk($sformatf("lat%0d", i), 32'(lat), 32'd4);
    check_result($sformatf("v%0d", i), i);
  endtask

  initial begin
    int exp_q [$];
    int sent, got, cyc, stall_left, stall_seen, stray;
    logic seen_first;
    logic [WIDTH-1:0] held;

    vecs[0]  = '{3'b010, 16'h8001, 4'd4,  16'hF800, 1'b0};
    vecs[1]  = '{3'b001, 16'h8001, 4'd4,  16'h0800, 1'b0};
    vecs[2]  = '{3'b011, 16'h8001, 4'd1,  16'h0003, 1'b1};
    vecs[3]  = '{3'b100, 16'h0001, 4'd1,  16'h8000, 1'b1};
    vecs[4]  = '{3'b000, 16'hFFFF, 4'd15, 16'h8000, 1'b1};
    vecs[5]  = '{3'b010, 16'h7FFF, 4'd15, 16'h0000, 1'b1};
    vecs[6]  = '{3'b000, 16'hA5A5, 4'd0,  16'hA5A5, 1'b0};
    vecs[7]  = '{3'b100, 16'h1234, 4'd0,  16'h1234, 1'b0};
    vecs[8]  = '{3'b110, 16'h1234, 4'd3,  16'h1234, 1'b0};
    vecs[9]  = '{3'b010, 16'h7FF0, 4'd4,  16'h07FF, 1'b0};
    vecs[10] = '{3'b111, 16'h0000, 4'd2,  16'h0000, 1'b0};
    vecs[11] = '{3'b011, 16'h1234, 4'd4,  16'h2341, 1'b1};
    vecs[12] = '{3'b100, 16'h1234, 4'd4,  16'h4123, 1'b0};
    vecs[13] = '{3'b001, 16'hFFFF, 4'd15, 16'h0001, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_shamt = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_flags",     32'({out_carry, out_zero, out_err}), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_single(i);

    // Back-to-back: 8 ops, 3-cycle stall once the first result appears.
    sent = 0; got = 0; cyc = 0; stall_left = 0; stall_seen = 0; seen_first = 1'b0;
    held = '0;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (out_valid && !seen_first) begin
        seen_first = 1'b1;
        stall_left = 3;
        held = out_data;
      end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (sent < 8) drive(sent); else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold",     32'(out_data), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("bp_extra", 32'd1, 32'd0);
        else check_result($sformatf("bp%0d", got), exp_q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(sent);
        sent++;
      end
    end
    chk("bp_count",  32'(got),        32'd8);
    chk("bp_stalls", 32'(stall_seen), 32'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Reset with three ops in flight; an op offered during reset must be dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(i + 2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive(4);
    @(negedge clk);
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1; in_valid = 1'b0;
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    chk("rst2_stale", 32'(stray), 32'd0);
    run_single(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_unit_pipe.md
Name: shift_unit_pipe

Overview:
- Parametrised, pipelined barrel shifter/rotator for the datapath ALU.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right on a WIDTH-bit operand.
- Uses one registered stage per shift-amount bit, with valid/ready handshakes on input and output.
- Produces zero, carry-out and illegal-op flags alongside the result.

Parameters:
- WIDTH, 16, operand/result width; must be a power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width and pipeline depth; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand, amount and op are valid this cycle.
- in_ready  output  1  unit accepts the input this cycle.
- in_data  input  WIDTH  operand A.
- in_shamt  input  SHW  shift amount, 0..WIDTH-1.
- in_op  input  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 illegal.
- out_valid  output  1  result held on outputs.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  shifted/rotated result.
- out_carry  output  1  last bit shifted or rotated out.
- out_zero  output  1  out_data == 0.
- out_err  output  1  illegal op code.

Behaviour:
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - SHW stages, numbered k = 0..SHW-1.
  - Stage k applies shift/rotate by 2^k when shamt bit k = 1; otherwise it passes the value through.
  - Each stage carries its own valid bit, op and remaining shamt bits.
- Latency: exactly SHW cycles from input transfer to out_valid with no stall (4 for WIDTH=16). Throughput is one op per cycle.
- Stall:
  - stall = out_valid && !out_ready.
  - While stalled, every stage register and all outputs hold.
  - in_ready = !stall, a combinational function of out_valid and out_ready.
  - Bubbles do not collapse.
- Fill rules:
  - SLL and SRL fill vacated bits with 0.
  - SRA fills every vacated bit with the original A[WIDTH-1].
  - ROL and ROR wrap bits around with no loss.
- Carry:
  - For amount n > 0: SLL/ROL give A[WIDTH-n]; SRL/SRA/ROR give A[n-1].
  - For n = 0: carry = 0.
  - Computed at entry and piped alongside the data.
- Illegal op (101-111): out_data = A unchanged, out_carry = 0, out_err = 1; the handshake is otherwise normal.
- Zero flag: out_zero reflects the final out_data, including the illegal-op case.
- Boundaries:
  - Amount 0 gives out_data = A for all ops.
  - Amount WIDTH-1 is the maximum; no wider amounts exist.
  - SRA on a positive operand equals SRL.
- Reset:
  - When rst_n = 0 at a clock edge, all stage valid bits, out_valid, out_data, out_carry, out_zero and out_err clear to 0.
  - In-flight ops are discarded, with no partial output.
  - in_ready = 1 during and after reset, but inputs presented while rst_n = 0 are dropped.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured; the pipeline advances.
- Stability: outputs change only on an output transfer, or when the last stage loads while out_valid = 0.

Test Plan (WIDTH=16):
- Arithmetic vs logical right: SRA A=0x8001 n=4 -> 0xF800, carry 0; SRL same operand -> 0x0800, carry 0; both 4 cycles after accept.
- Rotates: ROL A=0x8001 n=1 -> 0x0003, carry 1; ROR A=0x0001 n=1 -> 0x8000, carry 1.
- Extremes: SLL A=0xFFFF n=15 -> 0x8000, carry 1; SRA A=0x7FFF n=15 -> 0x0000, zero 1, carry 1; any op with n=0 -> A, carry 0.
- Back-to-back with backpressure:
  - Stimulus: 8 consecutive ops; out_ready held low for 3 cycles once the first result appears.
  - Required response: in_ready low during the stall, outputs stable, no op lost or duplicated, results in order.
- Illegal op and reset:
  - op=110 with A=0x1234 -> 0x1234, err 1.
  - rst_n low for 1 cycle with 3 ops in flight -> out_valid 0 next cycle and no stale results afterward.
